fifo_sync_param: RTL
====================

// Module: fifo_sync_param
// PURPOSE
//  Parametrised single-clock FIFO; next generation of the team's 8-bit/16-deep FIFO.
//  Adds: configurable width/depth, occupancy output, almost-full/almost-empty thresholds,
//  sticky overflow/underflow error flags, and a first-word-fall-through (FWFT) read mode.
//  Sits between producer/consumer blocks in the same clock domain as a rate-decoupling buffer.
// PARAMETERS
//  DATA_W     8           data width in bits (>=1)
//  DEPTH      16          number of entries; power of two, >=2
//  AF_THRESH  DEPTH-2     almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2           almost_empty asserted when count <= AE_THRESH
//  FWFT       0           0 = registered read (1-cycle latency); 1 = first-word-fall-through
// PORTS
//  clk           in   1                   rising-edge clock
//  reset         in   1                   synchronous, active-high reset
//  wr_en         in   1                   write request
//  data_in       in   DATA_W              write data
//  rd_en         in   1                   read (pop) request
//  data_out      out  DATA_W              read data
//  rd_valid      out  1                   data_out valid qualifier
//  full / empty  out  1                   count==DEPTH / count==0
//  almost_full   out  1                   count >= AF_THRESH
//  almost_empty  out  1                   count <= AE_THRESH
//  count         out  $clog2(DEPTH)+1     current occupancy, 0..DEPTH
//  err_clr       in   1                   clears overflow/underflow
//  overflow      out  1                   sticky: write attempted while full
//  underflow     out  1                   sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (sync, reset=1 at rising edge): wr_ptr=rd_ptr=0, count=0, data_out=0, rd_valid=0 (FWFT=0),
//    overflow=underflow=0. Memory array not cleared. wr_en/rd_en ignored while reset=1.
//    Reset mid-operation discards all stored entries; empty=1 the cycle after.
//  - wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty. full/empty evaluated on pre-edge state.
//  - Write on wr_acc: mem[wr_ptr]<=data_in, wr_ptr+1. Read on rd_acc: rd_ptr+1.
//  - Pointers are $clog2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally.
//  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither accepted.
//  - Full + wr_en + rd_en: read accepted, write rejected, overflow set; count -> DEPTH-1.
//  - Empty + wr_en + rd_en: write accepted, read rejected, underflow set; count -> 1.
//  - Flags full/empty/almost_* are combinational decodes of registered count (no extra latency).
//  - overflow set on wr_en & full; underflow set on rd_en & empty; both hold until err_clr or reset.
//    Set and err_clr in same cycle: set wins.
//  - FWFT=0: on rd_acc, data_out<=mem[rd_ptr] at that edge; rd_valid=1 for exactly the following
//    cycle; data_out otherwise holds last popped value.
//  - FWFT=1: data_out = mem[rd_ptr] whenever ~empty; rd_valid = ~empty; rd_en pops current head.
//    Word written into an empty FIFO appears on data_out the cycle after the write edge.
//  - Elaboration-time check: DEPTH power of two, AE_THRESH < AF_THRESH <= DEPTH; else $fatal.
// STRUCTURE
//  - Package fifo_pkg: default DATA_W/DEPTH constants and clog2 helper, shared by FIFO variants.
//  - Sub-module fifo_mem: DEPTH x DATA_W register array, one sync write port, one async read port.
//  - Top holds pointers, count, flag decode, error flags, FWFT/registered output mux (generate).
// TESTING (run each with FWFT=0 and FWFT=1; DATA_W=8, DEPTH=16 unless noted)
//  1 Reset, write 0x01..0x10 -> full=1, count=16, almost_full=1 from count 14; read 16 -> 0x01..0x10
//    in order, empty=1, FWFT=0 shows each word one cycle after its rd_en.
//  2 Full, wr_en=1 data 0xAA -> count stays 16, overflow=1 sticky; err_clr pulse -> overflow=0.
//  3 Empty, rd_en=1 -> count 0, data_out unchanged, rd_valid=0, underflow=1; empty+wr_en+rd_en with
//    0x55 -> count=1, underflow=1, 0x55 read next.
//  4 Count 8, wr_en+rd_en for 40 cycles with incrementing data -> count stays 8, pointers wrap >2x,
//    output order matches input order with no loss.
//  5 Count 10, assert reset one cycle mid-burst -> next cycle count=0, empty=1, flags 0, old data
//    never reappears on data_out.
//  6 DEPTH=4, DATA_W=32, AF=3, AE=1 -> write 0xDEADBEEF..: almost_empty at count<=1, almost_full at 3.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and helpers for the single-clock FIFO family.
//   - FIFO_DEF_DATA_W / FIFO_DEF_DEPTH : default geometry (8 bits x 16 entries)
//   - clog2()   : ceiling log2, usable in parameter expressions
//   - is_pow2() : true for powers of two >= 2
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int FIFO_DEF_DATA_W = 8;
  localparam int FIFO_DEF_DEPTH  = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
//   DEPTH x DATA_W register array: one synchronous write port, one
//   asynchronous (combinational) read port. Contents are never reset.
//   Ports:
//     clk      in   write clock
//     we_i     in   write enable
//     waddr_i  in   write address
//     wdata_i  in   write data
//     raddr_i  in   read address
//     rdata_o  out  read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DEF_DATA_W,
  parameter int DEPTH  = FIFO_DEF_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// -----------------------------------------------------------------------------
// fifo_sync_param
//   Parametrised single-clock FIFO with occupancy, almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags and an optional
//   first-word-fall-through (FWFT) read mode.
//   Ports:
//     clk           in   rising-edge clock
//     reset         in   synchronous active-high reset
//     wr_en         in   write request
//     data_in       in   write data
//     rd_en         in   read (pop) request
//     data_out      out  read data
//     rd_valid      out  data_out qualifier
//     full / empty  out  count==DEPTH / count==0
//     almost_full   out  count >= AF_THRESH
//     almost_empty  out  count <= AE_THRESH
//     count         out  occupancy 0..DEPTH
//     err_clr       in   clears overflow/underflow
//     overflow      out  sticky: write attempted while full
//     underflow     out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DEF_DATA_W,
  parameter int DEPTH     = FIFO_DEF_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   rd_en,
  output logic [DATA_W-1:0]      data_out,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  input  logic                   err_clr,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int PTR_W = clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!is_pow2(DEPTH) || !(AE_THRESH < AF_THRESH) || (AF_THRESH > DEPTH) || (DATA_W < 1))
  begin : g_param_err
    $fatal(1, "fifo_sync_param: DEPTH must be a power of two and AE_THRESH < AF_THRESH <= DEPTH");
  end

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              wr_acc, rd_acc;
  logic [DATA_W-1:0] head_data;

  // Flags decode the registered count directly, so they carry no extra latency.
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
  assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses pre-edge full/empty: a full FIFO still pops, an empty one
  // still pushes, when both requests arrive together.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (head_data)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Power-of-two depth lets the pointers wrap by plain overflow.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A new error event outranks a simultaneous clear.
    overflow_d  = (wr_en & full)  | (overflow_q  & ~err_clr);
    underflow_d = (rd_en & empty) | (underflow_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT == 1'b0) begin : g_reg_out
    logic [DATA_W-1:0] dout_q;
    logic              vld_q;

    // Registered read: the popped word lands on data_out at the pop edge and
    // is held until the next pop; rd_valid marks only the cycle after a pop.
    always_ff @(posedge clk) begin
      if (reset) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= head_data;
        end
      end
    end

    assign data_out = dout_q;
    assign rd_valid = vld_q;
  end else begin : g_fwft
    // The head is shown combinationally; when empty the output is forced to
    // zero so stale array contents (e.g. after a reset) never leak out.
    assign data_out = empty ? '0 : head_data;
    assign rd_valid = ~empty;
  end

endmodule
